// File: rtl/slave_tx_line_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : slave_tx_line_sequencer
//  Description : SIE TX port client that drives USB line states, either
//                continuously from a live input or as a timed pulse that
//                ends with a TX idle write. Optional macro
//                TX_LINE_CHG_ONLY_EN suppresses repeated identical
//                direct-control writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module slave_tx_line_sequencer #(
    parameter int         CNT_W        = 16,
    parameter logic [7:0] TX_DC_CODE   = 8'h00,
    parameter logic [7:0] TX_IDLE_CODE = 8'h03
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dc_en,
    input  logic [1:0]       dc_line_state,
    input  logic             pulse_start,
    input  logic [1:0]       pulse_line_state,
    input  logic [CNT_W-1:0] pulse_len,
    input  logic             tx_gnt,
    input  logic             tx_rdy,
    output logic             tx_req,
    output logic             tx_wen,
    output logic [7:0]       tx_data,
    output logic [7:0]       tx_cntl,
    output logic             pulse_busy,
    output logic             pulse_done
);

    typedef enum logic [3:0] {
        S_START         = 4'd0,
        S_CHK           = 4'd1,
        S_DC_WAIT_GNT   = 4'd2,
        S_DC_WAIT_RDY   = 4'd3,
        S_DC_LOOP       = 4'd4,
        S_P_WAIT_GNT    = 4'd5,
        S_P_WAIT_RDY    = 4'd6,
        S_P_HOLD        = 4'd7,
        S_IDLE_WAIT_RDY = 4'd8,
        S_IDLE_FIN      = 4'd9
    } state_t;

    localparam logic [CNT_W-1:0] c_cntOne = CNT_W'(1);

    state_t           r_state, w_state;
    logic             r_txReq, w_txReq;
    logic             r_txWen, w_txWen;
    logic [7:0]       r_txData, w_txData;
    logic [7:0]       r_txCntl, w_txCntl;
    logic             r_pulseBusy, w_pulseBusy;
    logic             r_pulseDone, w_pulseDone;
    logic             r_pulsePend, w_pulsePend;
    logic [1:0]       r_pulseLs, w_pulseLs;
    logic [CNT_W-1:0] r_pulseLen, w_pulseLen;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_fromPulse, w_fromPulse;
`ifdef TX_LINE_CHG_ONLY_EN
    logic [1:0]       r_lastLs, w_lastLs;
    logic             r_lastValid, w_lastValid;
`endif

    logic w_accept;
    logic w_pendEff;

    // A pulse accepted this very cycle already counts as pending, so it wins a tie with dc_en
    assign w_accept  = pulse_start & ~r_pulseBusy;
    assign w_pendEff = r_pulsePend | w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_START;
            r_txReq     <= 1'b0;
            r_txWen     <= 1'b0;
            r_txData    <= 8'h00;
            r_txCntl    <= 8'h00;
            r_pulseBusy <= 1'b0;
            r_pulseDone <= 1'b0;
            r_pulsePend <= 1'b0;
            r_pulseLs   <= 2'b00;
            r_pulseLen  <= '0;
            r_cnt       <= '0;
            r_fromPulse <= 1'b0;
`ifdef TX_LINE_CHG_ONLY_EN
            r_lastLs    <= 2'b00;
            r_lastValid <= 1'b0;
`endif
        end else begin
            r_state     <= w_state;
            r_txReq     <= w_txReq;
            r_txWen     <= w_txWen;
            r_txData    <= w_txData;
            r_txCntl    <= w_txCntl;
            r_pulseBusy <= w_pulseBusy;
            r_pulseDone <= w_pulseDone;
            r_pulsePend <= w_pulsePend;
            r_pulseLs   <= w_pulseLs;
            r_pulseLen  <= w_pulseLen;
            r_cnt       <= w_cnt;
            r_fromPulse <= w_fromPulse;
`ifdef TX_LINE_CHG_ONLY_EN
            r_lastLs    <= w_lastLs;
            r_lastValid <= w_lastValid;
`endif
        end
    end

    always_comb begin
        w_state     = r_state;
        w_txReq     = r_txReq;
        w_txWen     = 1'b0;
        w_txData    = r_txData;
        w_txCntl    = r_txCntl;
        w_pulseBusy = r_pulseBusy;
        w_pulseDone = 1'b0;
        w_pulsePend = r_pulsePend;
        w_pulseLs   = r_pulseLs;
        w_pulseLen  = r_pulseLen;
        w_cnt       = r_cnt;
        w_fromPulse = r_fromPulse;
`ifdef TX_LINE_CHG_ONLY_EN
        w_lastLs    = r_lastLs;
        w_lastValid = r_lastValid;
`endif

        if (w_accept) begin
            w_pulsePend = 1'b1;
            w_pulseBusy = 1'b1;
            w_pulseLs   = pulse_line_state;
            w_pulseLen  = (pulse_len == '0) ? c_cntOne : pulse_len;
        end

        case (r_state)
            S_START: w_state = S_CHK;
            S_CHK: begin
                if (w_pendEff) begin
                    w_txReq = 1'b1;
                    w_state = S_P_WAIT_GNT;
                end else if (dc_en) begin
                    w_txReq = 1'b1;
                    w_state = S_DC_WAIT_GNT;
`ifdef TX_LINE_CHG_ONLY_EN
                    w_lastValid = 1'b0;
`endif
                end else begin
                    w_txReq = 1'b0;
                end
            end
            S_DC_WAIT_GNT: if (tx_gnt) w_state = S_DC_WAIT_RDY;
            S_DC_WAIT_RDY: begin
`ifdef TX_LINE_CHG_ONLY_EN
                if (tx_rdy && (!r_lastValid || (dc_line_state != r_lastLs))) begin
                    w_txWen     = 1'b1;
                    w_txData    = {6'b0, dc_line_state};
                    w_txCntl    = TX_DC_CODE;
                    w_lastLs    = dc_line_state;
                    w_lastValid = 1'b1;
                    w_state     = S_DC_LOOP;
                end else if (w_pendEff || !dc_en) begin
                    w_state = S_IDLE_WAIT_RDY;
                end
`else
                if (tx_rdy) begin
                    w_txWen  = 1'b1;
                    w_txData = {6'b0, dc_line_state};
                    w_txCntl = TX_DC_CODE;
                    w_state  = S_DC_LOOP;
                end
`endif
            end
            S_DC_LOOP: begin
                if (w_pendEff || !dc_en) w_state = S_IDLE_WAIT_RDY;
                else                     w_state = S_DC_WAIT_RDY;
            end
            S_P_WAIT_GNT: if (tx_gnt) w_state = S_P_WAIT_RDY;
            S_P_WAIT_RDY: begin
                if (tx_rdy) begin
                    w_txWen     = 1'b1;
                    w_txData    = {6'b0, r_pulseLs};
                    w_txCntl    = TX_DC_CODE;
                    w_cnt       = r_pulseLen;
                    w_pulsePend = 1'b0;
                    w_fromPulse = 1'b1;
                    w_state     = S_P_HOLD;
                end
            end
            // Minimum load is 1, so the counter stops at 1 and never wraps
            S_P_HOLD: begin
                if (r_cnt == c_cntOne) w_state = S_IDLE_WAIT_RDY;
                else                   w_cnt   = r_cnt - c_cntOne;
            end
            S_IDLE_WAIT_RDY: begin
                if (tx_rdy) begin
                    w_txWen  = 1'b1;
                    w_txData = 8'h00;
                    w_txCntl = TX_IDLE_CODE;
                    w_state  = S_IDLE_FIN;
                end
            end
            S_IDLE_FIN: begin
                w_txReq = 1'b0;
                if (r_fromPulse) begin
                    w_pulseDone = 1'b1;
                    w_pulseBusy = 1'b0;
                    w_fromPulse = 1'b0;
                end
                w_state = S_CHK;
            end
            default: w_state = S_START;
        endcase
    end

    assign tx_req     = r_txReq;
    assign tx_wen     = r_txWen;
    assign tx_data    = r_txData;
    assign tx_cntl    = r_txCntl;
    assign pulse_busy = r_pulseBusy;
    assign pulse_done = r_pulseDone;

endmodule
`default_nettype wire

// File: tb/tb_slave_tx_line_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slave_tx_line_sequencer
//  Description : Scoreboard bench for slave_tx_line_sequencer: directed
//                stimulus queues expected TX writes, a monitor pops them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slave_tx_line_sequencer;

    localparam logic [7:0] c_DC   = 8'hA5;
    localparam logic [7:0] c_IDLE = 8'h3C;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] cntl;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        dc_en;
    logic [1:0]  dc_line_state;
    logic        pulse_start;
    logic [1:0]  pulse_line_state;
    logic [15:0] pulse_len;
    logic        tx_gnt;
    logic        tx_rdy;
    logic        tx_req;
    logic        tx_wen;
    logic [7:0]  tx_data;
    logic [7:0]  tx_cntl;
    logic        pulse_busy;
    logic        pulse_done;

    wr_t expQ[$];
    int  wrCyc[$];
    int  cyc     = 0;
    int  doneCnt = 0;
    int  checks  = 0;
    int  errors  = 0;
    int  dn0;

    slave_tx_line_sequencer #(
        .CNT_W       (16),
        .TX_DC_CODE  (c_DC),
        .TX_IDLE_CODE(c_IDLE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .dc_en           (dc_en),
        .dc_line_state   (dc_line_state),
        .pulse_start     (pulse_start),
        .pulse_line_state(pulse_line_state),
        .pulse_len       (pulse_len),
        .tx_gnt          (tx_gnt),
        .tx_rdy          (tx_rdy),
        .tx_req          (tx_req),
        .tx_wen          (tx_wen),
        .tx_data         (tx_data),
        .tx_cntl         (tx_cntl),
        .pulse_busy      (pulse_busy),
        .pulse_done      (pulse_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushW(input logic [7:0] d, input logic [7:0] c);
        wr_t e;
        e.data = d;
        e.cntl = c;
        expQ.push_back(e);
    endtask

    function automatic int gapOf(input int i);
        if (wrCyc.size() > i + 1) return wrCyc[i+1] - wrCyc[i];
        return -1;
    endfunction

    task automatic waitDone(input int d0, input int budget);
        int n = 0;
        while (doneCnt == d0 && n < budget) begin
            tick(1);
            n++;
        end
        check("done_timeout", 32'(doneCnt != d0), 32'd1);
    endtask

    // Monitor: every write strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && tx_wen) begin
            wrCyc.push_back(cyc);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got data=%0h cntl=%0h expected none", tx_data, tx_cntl);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                check("wr_data", 32'(tx_data), 32'(e.data));
                check("wr_cntl", 32'(tx_cntl), 32'(e.cntl));
            end
        end
        if (!rst && pulse_done) doneCnt++;
    end

    initial begin
        rst = 1'b1; dc_en = 1'b1; dc_line_state = 2'b01;
        pulse_start = 1'b0; pulse_line_state = 2'b00; pulse_len = 16'd0;
        tx_gnt = 1'b0; tx_rdy = 1'b0;

        // Reset state with dc_en held
        tick(5);
        check("rst_req",   32'(tx_req),     32'd0);
        check("rst_wen",   32'(tx_wen),     32'd0);
        check("rst_data",  32'(tx_data),    32'd0);
        check("rst_cntl",  32'(tx_cntl),    32'd0);
        check("rst_busy",  32'(pulse_busy), 32'd0);
        check("rst_done",  32'(pulse_done), 32'd0);
        rst = 1'b0;
        tick(1);
        check("req_1st_cycle", 32'(tx_req), 32'd0);
        tick(1);
        check("req_2nd_cycle", 32'(tx_req), 32'd1);

        // Abort while waiting for grant: no writes, request dropped
        tick(3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0; dc_en = 1'b0; tx_gnt = 1'b1; tx_rdy = 1'b1;
        tick(3);
        check("abort_req", 32'(tx_req), 32'd0);
        check("abort_writes", 32'(wrCyc.size()), 32'd0);

        // Continuous direct control, then exit through idle
        wrCyc.delete();
        dc_en = 1'b1; dc_line_state = 2'b01;
`ifdef TX_LINE_CHG_ONLY_EN
        pushW(8'h01, c_DC);
`else
        repeat (5) pushW(8'h01, c_DC);
`endif
        pushW(8'h00, c_IDLE);
        tick(5);
        check("dc_req_high", 32'(tx_req), 32'd1);
        tick(5);
        dc_en = 1'b0;
        tick(6);
        check("dc_req_low", 32'(tx_req), 32'd0);
        check("dc_queue_empty", 32'(expQ.size()), 32'd0);
`ifndef TX_LINE_CHG_ONLY_EN
        check("dc_strobe_gap", 32'(gapOf(0)), 32'd2);
`endif

        // Timed pulse, len=100
        wrCyc.delete();
        dn0 = doneCnt;
        pulse_start = 1'b1; pulse_line_state = 2'b10; pulse_len = 16'd100;
        pushW(8'h02, c_DC);
        pushW(8'h00, c_IDLE);
        tick(1);
        pulse_start = 1'b0; pulse_line_state = 2'b00; pulse_len = 16'd0;
        check("p100_busy", 32'(pulse_busy), 32'd1);
        waitDone(dn0, 200);
        tick(1);
        check("p100_gap", 32'(gapOf(0)), 32'd101);
        check("p100_busy_low", 32'(pulse_busy), 32'd0);
        check("p100_one_done", 32'(doneCnt - dn0), 32'd1);
        check("p100_queue_empty", 32'(expQ.size()), 32'd0);

        // len=0 behaves as 1; second request while busy is ignored
        wrCyc.delete();
        dn0 = doneCnt;
        pulse_start = 1'b1; pulse_line_state = 2'b11; pulse_len = 16'd0;
        pushW(8'h03, c_DC);
        pushW(8'h00, c_IDLE);
        tick(1);
        pulse_start = 1'b0;
        tick(1);
        pulse_start = 1'b1; pulse_line_state = 2'b01; pulse_len = 16'd5;
        tick(1);
        pulse_start = 1'b0;
        tick(10);
        check("p0_gap", 32'(gapOf(0)), 32'd2);
        check("p0_write_count", 32'(wrCyc.size()), 32'd2);
        check("p0_one_done", 32'(doneCnt - dn0), 32'd1);
        check("p0_busy_low", 32'(pulse_busy), 32'd0);

        // Pulse arriving during direct control, then DC resumes
        wrCyc.delete();
        dn0 = doneCnt;
        dc_en = 1'b1; dc_line_state = 2'b01;
`ifdef TX_LINE_CHG_ONLY_EN
        pushW(8'h01, c_DC);
`else
        pushW(8'h01, c_DC); pushW(8'h01, c_DC);
`endif
        pushW(8'h00, c_IDLE);
        pushW(8'h02, c_DC);
        pushW(8'h00, c_IDLE);
`ifdef TX_LINE_CHG_ONLY_EN
        pushW(8'h01, c_DC);
`else
        pushW(8'h01, c_DC); pushW(8'h01, c_DC);
`endif
        pushW(8'h00, c_IDLE);
        tick(5);
        pulse_start = 1'b1; pulse_line_state = 2'b10; pulse_len = 16'd10;
        tick(1);
        pulse_start = 1'b0; dc_line_state = 2'b00;
        tick(2);
        check("dcp_req_gap", 32'(tx_req), 32'd0);
        tick(1);
        check("dcp_req_back", 32'(tx_req), 32'd1);
        tick(11);
        dc_line_state = 2'b01;
        tick(7);
        dc_en = 1'b0;
        tick(6);
`ifdef TX_LINE_CHG_ONLY_EN
        check("dcp_hold_gap", 32'(gapOf(2)), 32'd11);
`else
        check("dcp_hold_gap", 32'(gapOf(3)), 32'd11);
`endif
        check("dcp_one_done", 32'(doneCnt - dn0), 32'd1);
        check("dcp_req_low", 32'(tx_req), 32'd0);
        check("dcp_queue_empty", 32'(expQ.size()), 32'd0);

`ifdef TX_LINE_CHG_ONLY_EN
        // Only line-state changes are written
        dc_en = 1'b1; dc_line_state = 2'b01;
        pushW(8'h01, c_DC);
        tick(20);
        dc_line_state = 2'b10;
        pushW(8'h02, c_DC);
        tick(6);
        dc_en = 1'b0;
        pushW(8'h00, c_IDLE);
        tick(6);
        check("chg_queue_empty", 32'(expQ.size()), 32'd0);
        check("chg_req_low", 32'(tx_req), 32'd0);
`endif

        // Reset during a pulse hold: no idle write, no completion
        dn0 = doneCnt;
        pulse_start = 1'b1; pulse_line_state = 2'b01; pulse_len = 16'd50;
        pushW(8'h01, c_DC);
        tick(1);
        pulse_start = 1'b0;
        tick(10);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(5);
        check("rstp_no_done", 32'(doneCnt - dn0), 32'd0);
        check("rstp_busy", 32'(pulse_busy), 32'd0);
        check("rstp_req", 32'(tx_req), 32'd0);
        check("rstp_queue_empty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
